wb_merge_unit: RTL and testbench
================================

// Module: wb_merge_unit
// PURPOSE
//  Parametrised writeback stage. Merges NUM_CH result producers into the single register-file write port.
//  - ch0: in-order pipeline; its writeback mux is applied at the input.
//  - ch1..NUM_CH-1: multi-cycle units, e.g. load-return and mul/div.
//  Each channel is buffered in a FIFO, round-robin arbitrated, and the result is registered onto the RF write port.
//  Also tracks halt retirement.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_AW      5   register address width
//  NUM_CH      2   producer channels (>=1); ch0 is the pipeline channel
//  FIFO_DEPTH  4   entries per channel FIFO (power of 2, >=2)
// PORTS
//  CLK          in   1              clock, rising edge
//  RST          in   1              asynchronous, active-low reset
//  p0_valid     in   1              ch0 result valid
//  p0_ready     out  1              ch0 accept
//  p0_pc        in   XLEN           ch0 PC
//  p0_wbsel     in   2              ch0 writeback select (WBSEL_* codes)
//  p0_alu       in   XLEN           ch0 ALU result
//  p0_load      in   XLEN           ch0 extended load data
//  p0_imm       in   XLEN           ch0 immediate
//  p0_rd        in   REG_AW         ch0 destination register
//  p0_halt      in   1              ch0 instruction is halt
//  px_valid     in   NUM_CH-1       ch1.. result valid, one bit per channel
//  px_ready     out  NUM_CH-1       ch1.. accept
//  px_data      in   (NUM_CH-1)*XLEN  ch1.. data, channel c at [(c-1)*XLEN +: XLEN]
//  px_rd        in   (NUM_CH-1)*REG_AW  ch1.. destination registers, same packing
//  rf_we        out  1              register-file write enable
//  rf_waddr     out  REG_AW         write address
//  rf_wdata     out  XLEN           write data
//  halted       out  1              halt retired and all FIFOs drained
//  occupancy    out  NUM_CH*3       per-channel FIFO count, saturating at 7
// BEHAVIOUR
//  - Reset (RST=0, async):
//    - all FIFOs empty; RR pointer=0; halt_seen=0.
//    - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, halted=0, occupancy=0.
//    - In-flight entries are discarded; they are not written.
//  - Handshake: transfer on valid&&ready at a rising edge.
//    - readyc = !fullc; p0_ready is additionally forced 0 once halt_seen=1.
//    - A full FIFO never accepts, even when popping in the same cycle.
//  - ch0 data stored = wbsel ALU:p0_alu | PC4:p0_pc+4 (mod 2^XLEN) | MEM:p0_load | IMM:p0_imm.
//  - ch0 halt:
//    - the entry is stored with rd forced to 0 and halt flag=1.
//    - halt_seen is set when it is accepted.
//  - Arbitration: each cycle, grant the first non-empty channel at or after the RR pointer.
//    - The granted head is popped; RR pointer <= grant+1 mod NUM_CH.
//    - No grant leaves the pointer unchanged.
//  - Output register, one edge after grant:
//    - rf_we = grant && rd!=0; rf_waddr/rf_wdata hold the popped entry's rd/data.
//    - When rf_we=0, waddr/wdata hold their previous values.
//    - rd==0 entries (incl. halt) are consumed without writing.
//  - Latency: accepted at edge N -> rf_we high in the cycle after edge N+1 (minimum, uncontended).
//  - Ordering: per-channel FIFO order is preserved; there is no ordering across channels.
//  - Simultaneous push+pop on a non-full FIFO: count unchanged; data is correct.
//  - halted rises one edge after: the halt entry has been popped AND all FIFOs are empty.
//    - It is sticky until reset.
// STRUCTURE
//  - Shared package/header:
//    - WBSEL_ALU=2'b00, WBSEL_PC4=2'b01, WBSEL_MEM=2'b10, WBSEL_IMM=2'b11.
//    - wb_entry layout {halt, rd, data}.
//  - One sub-module: wb_chan_fifo.
//    - Params WIDTH, DEPTH; ports push/pop/full/empty/count/head.
//    - One instance per channel via generate.
//  - Arbiter and output register live in the top level.
// TESTING
//  1. Reset mid-stream: 3 entries queued on ch0, RST low for 1 cycle -> occupancy=0, rf_we=0, nothing is written after release.
//  2. ch0 wbsel sweep: pc=0x100, alu=0xA, load=0xB, imm=0xC, rd=5 -> writes 0xA, 0x104, 0xB, 0xC to r5 in 4 consecutive cycles.
//  3. Contention with NUM_CH=2: both channels push every cycle -> writes alternate ch0,ch1; a full FIFO drops p?_ready to 0.
//  4. FIFO full boundary, DEPTH=4, arbiter starved by ch1:
//     - ch0 accepts 4 entries, then ready=0.
//     - One pop restores ready=1 the next cycle; all data is written in order.
//  5. rd=0 and halt:
//     - rd=0 result -> consumed, rf_we stays 0.
//     - halt accepted with 2 ch1 entries pending -> p0_ready=0; halted=1 only after both ch1 writes complete.

Source files
------------

// File: rtl/wb_merge_unit_pkg.sv
// Shared definitions for the writeback merge unit: writeback-select codes and
// the occupancy saturation helper. Entries are packed as {halt, rd, data}.
package wb_merge_unit_pkg;

  typedef enum logic [1:0] {
    WBSEL_ALU = 2'b00,
    WBSEL_PC4 = 2'b01,
    WBSEL_MEM = 2'b10,
    WBSEL_IMM = 2'b11
  } wbsel_e;

  localparam int OCC_W = 3;
  localparam logic [OCC_W-1:0] OCC_MAX = 3'd7;

  function automatic logic [OCC_W-1:0] occ_sat(input logic [31:0] count);
    logic [OCC_W-1:0] res;
    if (count > 32'd7) begin
      res = OCC_MAX;
    end else begin
      res = count[OCC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_merge_unit_fifo.sv
// Per-channel result FIFO. A full FIFO refuses pushes even when popping in
// the same cycle, so the producer-side ready depends only on stored state.
module wb_chan_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and count bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/wb_merge_unit.sv
// Writeback merge: NUM_CH producer FIFOs, round-robin arbitration and a
// registered register-file write port, plus halt retirement tracking.
module wb_merge_unit
  import wb_merge_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int NX        = (NUM_CH > 1) ? NUM_CH - 1 : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 p0_valid,
  output logic                 p0_ready,
  input  logic [XLEN-1:0]      p0_pc,
  input  logic [1:0]           p0_wbsel,
  input  logic [XLEN-1:0]      p0_alu,
  input  logic [XLEN-1:0]      p0_load,
  input  logic [XLEN-1:0]      p0_imm,
  input  logic [REG_AW-1:0]    p0_rd,
  input  logic                 p0_halt,
  input  logic [NX-1:0]        px_valid,
  output logic [NX-1:0]        px_ready,
  input  logic [NX*XLEN-1:0]   px_data,
  input  logic [NX*REG_AW-1:0] px_rd,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 halted,
  output logic [NUM_CH*3-1:0]  occupancy
);

  localparam int EW  = 1 + REG_AW + XLEN;
  localparam int RRW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [EW-1:0]     entry_s [NUM_CH];
  logic [EW-1:0]     head_s  [NUM_CH];
  logic [CW-1:0]     count_s [NUM_CH];

  logic [XLEN-1:0]   p0_data_s;
  logic [REG_AW-1:0] p0_rd_s;
  logic              grant_valid_s;
  logic [RRW-1:0]    grant_idx_s;
  logic [EW-1:0]     head_sel_s;
  int                idx;

  logic [RRW-1:0]    rr_r;
  logic              halt_seen_r;
  logic              halt_popped_r;
  logic              halted_r;
  logic              rf_we_r;
  logic [REG_AW-1:0] rf_waddr_r;
  logic [XLEN-1:0]   rf_wdata_r;

  // ch0 writeback mux; a halt retires through r0 so it never writes.
  always_comb begin
    p0_data_s = p0_alu;
    case (wbsel_e'(p0_wbsel))
      WBSEL_ALU: p0_data_s = p0_alu;
      WBSEL_PC4: p0_data_s = p0_pc + XLEN'(4);
      WBSEL_MEM: p0_data_s = p0_load;
      WBSEL_IMM: p0_data_s = p0_imm;
      default:   p0_data_s = p0_alu;
    endcase
    if (p0_halt) begin
      p0_rd_s = {REG_AW{1'b0}};
    end else begin
      p0_rd_s = p0_rd;
    end
  end

  assign entry_s[0] = {p0_halt, p0_rd_s, p0_data_s};
  assign p0_ready   = !full_s[0] && !halt_seen_r;
  assign push_s[0]  = p0_valid && p0_ready;

  for (genvar c = 1; c < NUM_CH; c++) begin : g_px
    assign entry_s[c]    = {1'b0, px_rd[(c-1)*REG_AW +: REG_AW], px_data[(c-1)*XLEN +: XLEN]};
    assign px_ready[c-1] = !full_s[c];
    assign push_s[c]     = px_valid[c-1] && px_ready[c-1];
  end

  if (NUM_CH == 1) begin : g_no_px
    assign px_ready = 1'b0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wb_chan_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RST),
      .push  (push_s[c]),
      .wdata (entry_s[c]),
      .pop   (pop_s[c]),
      .full  (full_s[c]),
      .empty (empty_s[c]),
      .count (count_s[c]),
      .head  (head_s[c])
    );
    assign pop_s[c]          = grant_valid_s && (grant_idx_s == RRW'(c));
    assign occupancy[c*3 +: 3] = occ_sat(32'(count_s[c]));
  end

  // Round-robin pick: scanning downwards lets the channel closest to rr_r win.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = RRW'(0);
    idx           = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx           = (int'(rr_r) + i) % NUM_CH;
      grant_idx_s   = empty_s[idx] ? grant_idx_s : RRW'(idx);
      grant_valid_s = grant_valid_s | ~empty_s[idx];
    end
  end

  assign head_sel_s = head_s[grant_idx_s];

  // Arbiter pointer, halt tracking and the registered RF write port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_r          <= RRW'(0);
      halt_seen_r   <= 1'b0;
      halt_popped_r <= 1'b0;
      halted_r      <= 1'b0;
      rf_we_r       <= 1'b0;
      rf_waddr_r    <= {REG_AW{1'b0}};
      rf_wdata_r    <= {XLEN{1'b0}};
    end else begin
      if (grant_valid_s) begin
        rr_r <= (grant_idx_s == RRW'(NUM_CH - 1)) ? RRW'(0) : grant_idx_s + RRW'(1);
      end else begin
        rr_r <= rr_r;
      end
      if (push_s[0] && p0_halt) halt_seen_r <= 1'b1;
      if (grant_valid_s && head_sel_s[EW-1]) halt_popped_r <= 1'b1;
      halted_r <= halted_r | (halt_popped_r && (&empty_s));
      if (grant_valid_s && (head_sel_s[XLEN +: REG_AW] != {REG_AW{1'b0}})) begin
        rf_we_r    <= 1'b1;
        rf_waddr_r <= head_sel_s[XLEN +: REG_AW];
        rf_wdata_r <= head_sel_s[XLEN-1:0];
      end else begin
        rf_we_r    <= 1'b0;
      end
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit (NUM_CH=2, FIFO_DEPTH=4) with
// hand-computed expectations.
module tb_wb_merge_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        p0_valid, p0_ready, p0_halt;
  logic [31:0] p0_pc, p0_alu, p0_load, p0_imm;
  logic [1:0]  p0_wbsel;
  logic [4:0]  p0_rd;
  logic [0:0]  px_valid, px_ready;
  logic [31:0] px_data;
  logic [4:0]  px_rd;
  logic        rf_we, halted;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  occupancy;

  int errors = 0;
  int checks = 0;

  wb_merge_unit #(.XLEN(32), .REG_AW(5), .NUM_CH(2), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_pc(p0_pc), .p0_wbsel(p0_wbsel),
    .p0_alu(p0_alu), .p0_load(p0_load), .p0_imm(p0_imm), .p0_rd(p0_rd), .p0_halt(p0_halt),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_rd(px_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halted(halted), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    p0_valid = 1'b0; p0_halt = 1'b0; p0_wbsel = 2'b00; p0_rd = 5'd0;
    p0_pc = 32'd0; p0_alu = 32'd0; p0_load = 32'd0; p0_imm = 32'd0;
    px_valid = 1'b0; px_data = 32'd0; px_rd = 5'd0;
  endtask

  task automatic reset_dut();
    idle();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  logic [31:0] exp2 [4];
  int n0, n1, w0, w1, last_ch, ch;
  logic acc0, acc1, both, saw_full0, saw_full1, wr_seen;

  initial begin
    idle();
    RST = 1'b0;
    tick();
    tick();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_p0_ready", 32'(p0_ready), 32'd1);
    RST = 1'b1;

    // Reset mid-stream with 3 entries queued in each channel
    for (int k = 1; k <= 5; k++) begin
      p0_valid = 1'b1; p0_wbsel = 2'b00; p0_alu = 32'h10 + 32'(k); p0_rd = 5'd1;
      px_valid = 1'b1; px_data = 32'h20 + 32'(k); px_rd = 5'd2;
      tick();
    end
    chk("t1_occ_before", 32'(occupancy), 32'h1b);
    idle();
    RST = 1'b0;
    #1;
    chk("t1_occ_in_reset", 32'(occupancy), 32'd0);
    chk("t1_we_in_reset", 32'(rf_we), 32'd0);
    tick();
    RST = 1'b1;
    wr_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      wr_seen = wr_seen | rf_we;
    end
    chk("t1_no_write_after", 32'(wr_seen), 32'd0);
    chk("t1_occ_after", 32'(occupancy), 32'd0);

    // wbsel sweep on ch0
    exp2[0] = 32'hA; exp2[1] = 32'h104; exp2[2] = 32'hB; exp2[3] = 32'hC;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        p0_valid = 1'b1; p0_wbsel = 2'(k); p0_pc = 32'h100; p0_alu = 32'hA;
        p0_load = 32'hB; p0_imm = 32'hC; p0_rd = 5'd5;
      end else begin
        idle();
      end
      tick();
      if (k >= 1) begin
        chk("t2_we", 32'(rf_we), 32'd1);
        chk("t2_waddr", 32'(rf_waddr), 32'd5);
        chk("t2_wdata", rf_wdata, exp2[k-1]);
      end
    end
    tick();
    chk("t2_we_idle", 32'(rf_we), 32'd0);
    chk("t2_wdata_hold", rf_wdata, 32'hC);

    // Contention and full-FIFO boundary
    reset_dut();
    n0 = 0; n1 = 0; w0 = 0; w1 = 0; last_ch = 2;
    saw_full0 = 1'b0; saw_full1 = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc <= 12) begin
        p0_valid = 1'b1; p0_wbsel = 2'b00; p0_alu = 32'h300 + 32'(n0); p0_rd = 5'd3;
        px_valid = 1'b1; px_data = 32'h400 + 32'(n1); px_rd = 5'd4;
      end else begin
        idle();
      end
      acc0 = p0_valid && p0_ready;
      acc1 = px_valid[0] && px_ready[0];
      if (p0_valid && !p0_ready) saw_full0 = 1'b1;
      if (px_valid[0] && !px_ready[0]) saw_full1 = 1'b1;
      tick();
      if (rf_we) begin
        ch = (rf_waddr == 5'd3) ? 0 : ((rf_waddr == 5'd4) ? 1 : 2);
        both = (w0 < n0) && (w1 < n1);
        chk("t3_waddr_known", 32'(ch < 2), 32'd1);
        if (both && last_ch != 2) chk("t3_alternate", 32'(ch), 32'(1 - last_ch));
        if (ch == 0) begin
          chk("t3_ch0_pending", 32'(w0 < n0), 32'd1);
          chk("t3_ch0_data", rf_wdata, 32'h300 + 32'(w0));
          w0++;
        end else if (ch == 1) begin
          chk("t3_ch1_pending", 32'(w1 < n1), 32'd1);
          chk("t3_ch1_data", rf_wdata, 32'h400 + 32'(w1));
          w1++;
        end
        last_ch = ch;
      end
      if (acc0) n0++;
      if (acc1) n1++;
      if (cyc == 7) begin
        chk("t4_occ_ch0_full", 32'(occupancy), 32'h1c);
        chk("t4_p0_ready_full", 32'(p0_ready), 32'd0);
        chk("t4_px_ready", 32'(px_ready), 32'd1);
      end
      if (cyc == 8) begin
        chk("t4_occ_after_pop", 32'(occupancy), 32'h23);
        chk("t4_p0_ready_back", 32'(p0_ready), 32'd1);
        chk("t4_px_ready_full", 32'(px_ready), 32'd0);
      end
    end
    chk("t3_ch0_drained", 32'(w0), 32'(n0));
    chk("t3_ch1_drained", 32'(w1), 32'(n1));
    chk("t3_saw_full0", 32'(saw_full0), 32'd1);
    chk("t3_saw_full1", 32'(saw_full1), 32'd1);

    // rd=0 consumption, then halt with two ch1 entries pending
    reset_dut();
    p0_valid = 1'b1; p0_wbsel = 2'b00; p0_alu = 32'h55; p0_rd = 5'd0;
    tick();
    idle();
    tick();
    chk("t5_rd0_no_write", 32'(rf_we), 32'd0);
    chk("t5_rd0_consumed", 32'(occupancy), 32'd0);
    p0_valid = 1'b1; p0_alu = 32'h56; p0_rd = 5'd0;
    px_valid = 1'b1; px_data = 32'h71; px_rd = 5'd7;
    tick();
    p0_alu = 32'h57; px_data = 32'h72;
    tick();
    chk("t5_w71_we", 32'(rf_we), 32'd1);
    chk("t5_w71_data", rf_wdata, 32'h71);
    p0_halt = 1'b1; p0_rd = 5'd9; p0_alu = 32'h99; px_data = 32'h73;
    chk("t5_ready_pre_halt", 32'(p0_ready), 32'd1);
    tick();
    chk("t5_dummy_no_write", 32'(rf_we), 32'd0);
    chk("t5_ready_after_halt", 32'(p0_ready), 32'd0);
    px_valid = 1'b0;
    p0_halt = 1'b0; p0_rd = 5'd10; p0_alu = 32'hEE;
    tick();
    chk("t5_w72_data", rf_wdata, 32'h72);
    chk("t5_w72_addr", 32'(rf_waddr), 32'd7);
    chk("t5_halted_early1", 32'(halted), 32'd0);
    tick();
    chk("t5_dummy2_no_write", 32'(rf_we), 32'd0);
    tick();
    chk("t5_w73_we", 32'(rf_we), 32'd1);
    chk("t5_w73_data", rf_wdata, 32'h73);
    chk("t5_halted_early2", 32'(halted), 32'd0);
    tick();
    chk("t5_halt_no_write", 32'(rf_we), 32'd0);
    chk("t5_halted_early3", 32'(halted), 32'd0);
    chk("t5_occ_empty", 32'(occupancy), 32'd0);
    tick();
    chk("t5_halted", 32'(halted), 32'd1);
    wr_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      wr_seen = wr_seen | rf_we;
    end
    chk("t5_halted_sticky", 32'(halted), 32'd1);
    chk("t5_no_post_halt_write", 32'(wr_seen), 32'd0);
    chk("t5_p0_ready_low", 32'(p0_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
